// File: rtl/stage_ex_md_if.sv
// Handshake bundle between ID/MEM and the iterative mul/div execute unit.
interface stage_ex_md_if #(
    parameter int XLEN    = 32,
    parameter int RD_BITS = 5
);
    logic               exn;
    logic               in_valid;
    logic [2:0]         in_op;
    logic [XLEN-1:0]    in_a;
    logic [XLEN-1:0]    in_b;
    logic [RD_BITS-1:0] in_rd;
    logic               mem_stall;
    logic               stall;
    logic               out_valid;
    logic [XLEN-1:0]    out_res;
    logic [RD_BITS-1:0] out_rd;
    logic               busy;

    modport master (
        output exn, in_valid, in_op, in_a, in_b, in_rd, mem_stall,
        input  stall, out_valid, out_res, out_rd, busy
    );
    modport slave (
        input  exn, in_valid, in_op, in_a, in_b, in_rd, mem_stall,
        output stall, out_valid, out_res, out_rd, busy
    );
endinterface

// File: rtl/stage_ex_md.sv
// Iterative multiply/divide execute unit: shift-add multiply, restoring divide,
// UNROLL result bits per cycle, sign fix-up in a final FIX cycle.
module stage_ex_md #(
    parameter int XLEN    = 32,
    parameter int UNROLL  = 1,
    parameter int RD_BITS = 5
) (
    input  logic          clk,
    input  logic          rst,
    stage_ex_md_if.slave  md
);
    localparam int N  = XLEN / UNROLL;
    localparam int CW = (N > 1) ? $clog2(N) : 1;
    localparam logic [CW-1:0] CNT_INIT = CW'(N - 1);

    typedef enum logic [1:0] {IDLE, CALC, FIX, DONE} state_t;

    state_t             r_state, w_next;
    logic [CW-1:0]      r_cnt;
    logic [2:0]         r_op;
    logic [RD_BITS-1:0] r_rd;
    logic               r_sa, r_sb, r_bzero;
    logic [XLEN-1:0]    r_hi, r_lo, r_opnd;

    logic               w_accept, w_div, w_sgn, w_is_div;
    logic [2:0]         w_op;
    logic [XLEN-1:0]    w_abs_a, w_abs_b, w_hi, w_lo, w_quo, w_rmd, w_res;
    logic [XLEN:0]      w_sum, w_rem;
    logic [2*XLEN-1:0]  w_prod;

    // Reserved opcode 7 collapses to MUL at decode.
    assign w_op     = (md.in_op == 3'd7) ? 3'd0 : md.in_op;
    assign w_div    = (w_op >= 3'd3);
    assign w_sgn    = (w_op == 3'd1) || (w_op == 3'd3) || (w_op == 3'd5);
    assign w_abs_a  = (w_sgn && md.in_a[XLEN-1]) ? -md.in_a : md.in_a;
    assign w_abs_b  = (w_sgn && md.in_b[XLEN-1]) ? -md.in_b : md.in_b;
    assign w_is_div = (r_op >= 3'd3);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_state <= IDLE;
        else     r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE: if (w_accept) w_next = CALC;
            CALC: if (r_cnt == '0) w_next = FIX;
            FIX:  w_next = DONE;
            DONE: if (!md.mem_stall) w_next = w_accept ? CALC : IDLE;
            default: w_next = IDLE;
        endcase
        if (md.exn) w_next = IDLE;
    end

    always_comb begin
        w_accept = ((r_state == IDLE) || (r_state == DONE)) &&
                   md.in_valid && !md.mem_stall && !md.exn;
        md.stall = (r_state == CALC) || (r_state == FIX) || md.mem_stall;
        md.busy  = (r_state != IDLE);
    end

    // r_hi:r_lo is the product accumulator for multiply, remainder:quotient for divide.
    always_comb begin
        w_hi  = r_hi;
        w_lo  = r_lo;
        w_sum = '0;
        w_rem = '0;
        for (int k = 0; k < UNROLL; k++) begin
            if (w_is_div) begin
                w_rem = {w_hi, w_lo[XLEN-1]};
                w_lo  = {w_lo[XLEN-2:0], 1'b0};
                if (w_rem >= {1'b0, r_opnd}) begin
                    w_rem = w_rem - {1'b0, r_opnd};
                    w_lo[0] = 1'b1;
                end
                w_hi = w_rem[XLEN-1:0];
            end else begin
                w_sum = {1'b0, w_hi} + (w_lo[0] ? {1'b0, r_opnd} : '0);
                w_lo  = {w_sum[0], w_lo[XLEN-1:1]};
                w_hi  = w_sum[XLEN:1];
            end
        end
    end

    // Divide-by-zero keeps the all-ones quotient unsigned, whatever the dividend sign.
    always_comb begin
        w_prod = {r_hi, r_lo};
        if (r_sa ^ r_sb) w_prod = -w_prod;
        w_quo = ((r_sa ^ r_sb) && !r_bzero) ? -r_lo : r_lo;
        w_rmd = r_sa ? -r_hi : r_hi;
        case (r_op)
            3'd0:       w_res = w_prod[XLEN-1:0];
            3'd1, 3'd2: w_res = w_prod[2*XLEN-1:XLEN];
            3'd3, 3'd4: w_res = w_quo;
            default:    w_res = w_rmd;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cnt        <= '0;
            r_op         <= '0;
            r_rd         <= '0;
            r_sa         <= 1'b0;
            r_sb         <= 1'b0;
            r_bzero      <= 1'b0;
            r_hi         <= '0;
            r_lo         <= '0;
            r_opnd       <= '0;
            md.out_valid <= 1'b0;
            md.out_res   <= '0;
            md.out_rd    <= '0;
        end else begin
            md.out_valid <= (w_next == DONE);
            if (w_accept) begin
                r_cnt   <= CNT_INIT;
                r_op    <= w_op;
                r_rd    <= md.in_rd;
                r_sa    <= w_sgn & md.in_a[XLEN-1];
                r_sb    <= w_sgn & md.in_b[XLEN-1];
                r_bzero <= (md.in_b == '0);
                r_hi    <= '0;
                r_lo    <= w_div ? w_abs_a : w_abs_b;
                r_opnd  <= w_div ? w_abs_b : w_abs_a;
            end else if (r_state == CALC) begin
                r_hi <= w_hi;
                r_lo <= w_lo;
                if (r_cnt != '0) r_cnt <= r_cnt - CW'(1);
            end else if (r_state == FIX) begin
                md.out_res <= w_res;
                md.out_rd  <= r_rd;
            end
        end
    end
endmodule

// File: tb/tb_stage_ex_md.sv
// Self-checking bench: directed literal cases plus a randomized run scored
// against a cycle-count behavioural model of the mul/div unit.
module tb_stage_ex_md;
    localparam int XLEN   = 32;
    localparam int UNROLL = 1;
    localparam int N      = XLEN / UNROLL;
    localparam int LIMIT  = 4 * N + 40;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checks = 0;
    int   failures = 0;
    int   cyc = 0;

    stage_ex_md_if #(.XLEN(XLEN), .RD_BITS(5)) md ();
    stage_ex_md #(.XLEN(XLEN), .UNROLL(UNROLL), .RD_BITS(5)) dut (.clk(clk), .rst(rst), .md(md));

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic logic [31:0] ref_calc(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
        logic [63:0]        up;
        logic signed [63:0] sp;
        logic signed [31:0] sa, sb;
        logic               ovf;
        sa  = a;
        sb  = b;
        up  = {32'd0, a} * {32'd0, b};
        sp  = $signed({{32{a[31]}}, a}) * $signed({{32{b[31]}}, b});
        ovf = (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);
        case (op)
            3'd1: return sp[63:32];
            3'd2: return up[63:32];
            3'd3: return (b == 0) ? 32'hFFFF_FFFF : ovf ? a : 32'(sa / sb);
            3'd4: return (b == 0) ? 32'hFFFF_FFFF : a / b;
            3'd5: return (b == 0) ? a : ovf ? 32'd0 : 32'(sa % sb);
            3'd6: return (b == 0) ? a : a % b;
            default: return up[31:0];
        endcase
    endfunction

    // Model: an accepted op occupies N+2 cycles, then its result is shown until MEM takes it.
    logic        m_valid;
    int          m_cnt;
    logic [31:0] m_res, m_pend;
    logic [4:0]  m_rd, m_prd;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_valid <= 1'b0;
            m_cnt   <= 0;
            m_res   <= '0;
            m_rd    <= '0;
        end else if (md.exn) begin
            m_valid <= 1'b0;
            m_cnt   <= 0;
        end else if (m_cnt > 0) begin
            m_cnt <= m_cnt - 1;
            if (m_cnt == 1) begin
                m_valid <= 1'b1;
                m_res   <= m_pend;
                m_rd    <= m_prd;
            end
        end else if (!md.mem_stall) begin
            m_valid <= 1'b0;
            if (md.in_valid) begin
                m_cnt  <= N + 1;
                m_pend <= ref_calc(md.in_op, md.in_a, md.in_b);
                m_prd  <= md.in_rd;
            end
        end
    end

    always @(negedge clk) begin
        #2;
        if (!rst) begin
            chk("mdl_out_valid", 32'(md.out_valid), 32'(m_valid));
            if (m_valid) begin
                chk("mdl_out_res", md.out_res, m_res);
                chk("mdl_out_rd", 32'(md.out_rd), 32'(m_rd));
            end
            chk("mdl_stall", 32'(md.stall), 32'((m_cnt > 0) || md.mem_stall));
            chk("mdl_busy", 32'(md.busy), 32'((m_cnt > 0) || m_valid));
        end
    end

    // Called at a negedge; returns at the following negedge once the op is accepted.
    task automatic issue(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                         input logic [4:0] rd, output int t0);
        int k = 0;
        md.in_op = op; md.in_a = a; md.in_b = b; md.in_rd = rd; md.in_valid = 1'b1;
        #1;
        while (md.stall && k < LIMIT) begin
            @(negedge clk); #1; k++;
        end
        chk("issue_accept_stall", 32'(md.stall), 32'd0);
        t0 = cyc;
        @(posedge clk);
        @(negedge clk);
        md.in_valid = 1'b0;
    endtask

    task automatic wait_res(input int t0, input logic [31:0] exp, input logic [4:0] erd, input string name);
        int k = 0;
        #1;
        while (!md.out_valid && k < LIMIT) begin
            @(negedge clk); #1; k++;
        end
        chk({name, "_valid"}, 32'(md.out_valid), 32'd1);
        chk({name, "_res"}, md.out_res, exp);
        chk({name, "_rd"}, 32'(md.out_rd), 32'(erd));
        chk({name, "_latency"}, 32'(cyc - t0), 32'(N + 2));
    endtask

    function automatic logic [31:0] rnd_val();
        case ($urandom_range(0, 5))
            0: return 32'd0;
            1: return 32'hFFFF_FFFF;
            2: return 32'h8000_0000;
            3: return 32'($urandom_range(0, 20));
            default: return $urandom;
        endcase
    endfunction

    typedef struct {
        logic [2:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] e;
    } vec_t;

    initial begin
        int   t, t2, tdone, nv;
        vec_t tv[13];
        tv = '{
            '{3'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0001},
            '{3'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0000},
            '{3'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE},
            '{3'd3, 32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFD},
            '{3'd5, 32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFF},
            '{3'd4, 32'h8000_0000, 32'd0,         32'hFFFF_FFFF},
            '{3'd6, 32'h8000_0000, 32'd0,         32'h8000_0000},
            '{3'd3, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000},
            '{3'd5, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000},
            '{3'd0, 32'd7,         32'd0,         32'h0000_0000},
            '{3'd3, 32'hFFFF_FFF9, 32'd0,         32'hFFFF_FFFF},
            '{3'd5, 32'hFFFF_FFF9, 32'd0,         32'hFFFF_FFF9},
            '{3'd7, 32'd3,         32'd5,         32'd15}
        };
        md.exn = 1'b0; md.in_valid = 1'b0; md.in_op = '0; md.in_a = '0; md.in_b = '0;
        md.in_rd = '0; md.mem_stall = 1'b0;

        repeat (2) @(negedge clk);
        #1;
        chk("rst_out_valid", 32'(md.out_valid), 32'd0);
        chk("rst_out_res", md.out_res, 32'd0);
        chk("rst_out_rd", 32'(md.out_rd), 32'd0);
        chk("rst_stall", 32'(md.stall), 32'd0);
        chk("rst_busy", 32'(md.busy), 32'd0);
        rst = 1'b0;
        @(negedge clk);

        // Reset while dividing, then a fresh multiply.
        issue(3'd3, 32'd100, 32'd7, 5'd1, t);
        repeat (4) @(negedge clk);
        rst = 1'b1;
        #1;
        chk("midrst_busy", 32'(md.busy), 32'd0);
        chk("midrst_valid", 32'(md.out_valid), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        issue(3'd0, 32'd3, 32'd4, 5'd2, t);
        wait_res(t, 32'd12, 5'd2, "mul3x4");

        foreach (tv[i]) begin
            issue(tv[i].op, tv[i].a, tv[i].b, 5'(i + 8), t);
            wait_res(t, tv[i].e, 5'(i + 8), $sformatf("vec%0d", i));
        end

        // Result held under MEM stall; queued DIVU accepted on release.
        issue(3'd0, 32'd6, 32'd7, 5'd5, t);
        wait_res(t, 32'd42, 5'd5, "mul42");
        tdone = cyc;
        md.mem_stall = 1'b1;
        md.in_op = 3'd4; md.in_a = 32'd9; md.in_b = 32'd3; md.in_rd = 5'd6; md.in_valid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            #1;
            chk("hold_valid", 32'(md.out_valid), 32'd1);
            chk("hold_res", md.out_res, 32'd42);
            chk("hold_rd", 32'(md.out_rd), 32'd5);
            chk("hold_stall", 32'(md.stall), 32'd1);
            @(negedge clk);
        end
        md.mem_stall = 1'b0;
        issue(3'd4, 32'd9, 32'd3, 5'd6, t);
        chk("release_accept_cycle", 32'(t - tdone), 32'd3);
        wait_res(t, 32'd3, 5'd6, "divu9_3");

        // Exception kills MULHU in flight; exn with in_valid in IDLE drops the op.
        issue(3'd2, 32'hFFFF_FFFF, 32'd2, 5'd7, t);
        repeat (3) @(negedge clk);
        md.exn = 1'b1;
        @(negedge clk);
        md.exn = 1'b0;
        #1;
        chk("exn_busy", 32'(md.busy), 32'd0);
        chk("exn_valid", 32'(md.out_valid), 32'd0);
        nv = 0;
        repeat (N + 4) begin
            @(negedge clk); #1;
            if (md.out_valid) nv++;
        end
        chk("exn_no_result", 32'(nv), 32'd0);
        @(negedge clk);
        md.exn = 1'b1; md.in_valid = 1'b1; md.in_op = 3'd0; md.in_a = 32'd2; md.in_b = 32'd2;
        @(negedge clk);
        md.exn = 1'b0; md.in_valid = 1'b0;
        #1;
        chk("exn_drop_busy", 32'(md.busy), 32'd0);
        @(negedge clk);

        // Back-to-back with no MEM stall.
        issue(3'd0, 32'd5, 32'd6, 5'd3, t);
        wait_res(t, 32'd30, 5'd3, "b2b_mul");
        issue(3'd5, 32'd17, 32'd5, 5'd4, t2);
        chk("b2b_gap", 32'(t2 - t), 32'(N + 2));
        wait_res(t2, 32'd2, 5'd4, "b2b_rem");

        // Randomized traffic, scored by the model every cycle.
        repeat (3000) begin
            @(negedge clk);
            md.in_valid  = ($urandom_range(0, 2) != 0);
            md.in_op     = 3'($urandom_range(0, 7));
            md.in_a      = rnd_val();
            md.in_b      = rnd_val();
            md.in_rd     = 5'($urandom);
            md.mem_stall = ($urandom_range(0, 3) == 0);
            md.exn       = ($urandom_range(0, 199) == 0);
        end
        @(negedge clk);
        md.in_valid = 1'b0; md.mem_stall = 1'b0; md.exn = 1'b0;
        repeat (N + 6) @(negedge clk);
        #3;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/stage_ex_md.md
Name: stage_ex_md

Overview:
Multi-cycle integer multiply/divide execute unit. It sits beside the single-cycle EX stage, between ID and MEM, and uses the same stall/bubble pipeline contract: capture from ID, hold under MEM stall, kill on exception. It computes MUL/MULH/MULHU/DIV/DIVU/REM/REMU iteratively. UNROLL result bits are processed per cycle, and upstream is stalled while the unit is busy.

Parameters:
XLEN, 32, operand/result width; must be a multiple of UNROLL
UNROLL, 1, iteration bits per cycle (1, 2 or 4); iteration count N = XLEN/UNROLL
RD_BITS, 5, destination register index width

Ports:
clk  in  1  clock
rst  in  1  asynchronous active-high reset
exn  in  1  exception flush; aborts any operation in flight
in_valid  in  1  ID presents a non-bubble mul/div op
in_op  in  3  0 MUL, 1 MULH, 2 MULHU, 3 DIV, 4 DIVU, 5 REM, 6 REMU, 7 reserved (treated as MUL)
in_a  in  XLEN  operand 1 (already forwarded)
in_b  in  XLEN  operand 2 (already forwarded)
in_rd  in  RD_BITS  destination register
mem_stall  in  1  MEM cannot accept a result this cycle
stall  out  1  to ID: hold current instruction
out_valid  out  1  result valid to MEM (w_rd qualifier)
out_res  out  XLEN  result
out_rd  out  RD_BITS  destination register
busy  out  1  state != IDLE

Behaviour:
- Reset (asynchronous, immediate): state IDLE, counter 0, out_valid 0, out_res 0, out_rd 0; stall and busy are 0 after reset.
- States:
  - IDLE: accept an op when in_valid && !mem_stall && !exn. On accept, latch op, rd, absolute operands and sign flags; go to CALC with counter = N-1.
  - CALC: one UNROLL-bit step per cycle (shift-add multiply over a 2*XLEN accumulator; restoring divide). When counter == 0, go to FIX; otherwise decrement counter.
  - FIX: apply sign correction and select the high or low word, quotient or remainder; write out_res and set out_valid = 1; go to DONE.
  - DONE: hold out_valid, out_res and out_rd while mem_stall.
    - If !mem_stall and in_valid, accept the next op (back-to-back) and go to CALC.
    - If !mem_stall and !in_valid, go to IDLE.
    - out_valid clears on the cycle the unit leaves DONE, unless a new result is being produced.
- Latency: accept at cycle t gives out_valid at cycle t+N+2. Total occupancy is N+2 cycles per op with no MEM stall.
- stall = (state==CALC) || (state==FIX) || mem_stall. stall is combinational, so ID holds its instruction until the cycle of accept.
- exn: takes priority over everything. Next state is IDLE, out_valid 0, and no op is accepted that cycle. The counter and datapath need not clear.
- Simultaneous exn and in_valid: the op is dropped.
- Arithmetic:
  - MUL returns the low XLEN bits.
  - MULH: signed×signed, high XLEN bits.
  - MULHU: unsigned×unsigned, high XLEN bits.
  - DIV/REM truncate toward zero; the remainder takes the dividend's sign.
- Divide boundaries:
  - Division by zero: DIV/DIVU quotient = all ones; REM/REMU = dividend. The full N cycles are still taken, so latency stays fixed.
  - Signed overflow (DIV of -2^(XLEN-1) by -1): quotient = -2^(XLEN-1), REM = 0.
- in_b == 0 for MUL: result 0 through the normal iteration path.
- Counter width is clog2(N), minimum 1. It does not wrap: the CALC exit happens at 0.

Test Plan:
- Reset mid-CALC: apply DIV 100/7, assert rst at cycle 5 -> out_valid drops immediately, busy=0. After release, a new MUL 3*4 returns 12 at t+N+2 = t+34 (UNROLL=1).
- MUL/MULH/MULHU with a=0xFFFFFFFF, b=0xFFFFFFFF -> 0x00000001, 0x00000000, 0xFFFFFFFE. Repeat with UNROLL=2 and 4: identical results at latency 18 and 10.
- DIV/REM: -7/2 -> -3 (0xFFFFFFFD), rem -1. DIVU 0x80000000/0 -> 0xFFFFFFFF, REMU -> 0x80000000. DIV 0x80000000/-1 -> 0x80000000, REM -> 0.
- MEM stall on result: assert mem_stall for 3 cycles while in DONE with result 42 -> out_valid, out_res=42 and out_rd held stable, stall=1. After release, in the same cycle, a queued DIVU 9/3 is accepted; 3 appears N+2 cycles later.
- Exception flush: exn pulsed during CALC of MULHU -> the next cycle is IDLE with out_valid=0 and no result for that rd. Exn asserted together with in_valid in IDLE -> the op is not accepted and busy stays 0.
- Back-to-back ops with mem_stall=0: MUL 5*6 then REM 17%5 -> results 30 and 2 on consecutive out_valid windows separated by exactly N+2 cycles; stall is high throughout each CALC/FIX period.
